// File: rtl/pgm_rep.sv
// rtl/pgm_rep.sv - packet generator/replicator with in-band configuration
//
// Captures one packet (PHV, up to DEPTH data beats, valid flag) and replays it
// REP_CNT times downstream with GAP idle cycles between copies. REP_CNT and GAP
// are written by control packets on the cin/cout chain; every control beat is
// forwarded to cout one cycle later.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_pgm_phv/_wr                    upstream PHV and strobe (packet start)
//   in_pgm_data/_wr                   upstream data beat and strobe
//   in_pgm_valid/_wr                  upstream keep/drop flag and strobe (packet end)
//   out_pgm_alf, out_pgm_phv_alf      almost-full to upstream
//   out_pgm_phv/_wr                   replayed PHV and strobe
//   out_pgm_data/_wr                  replayed beat and strobe
//   out_pgm_valid/_wr                 replayed valid flag (always 1) and strobe
//   in_pgm_phv_alf, in_pgm_alf        downstream almost-full
//   out_pgm_sent_start_flag           pulse with the first copy's PHV
//   out_pgm_sent_finish_flag          pulse with the last copy's valid strobe
//   cin_pgm_data/_wr, cin_pgm_ready   control chain input / downstream ready
//   cout_pgm_data/_wr, cout_pgm_ready control chain output
module pgm_rep #(
   parameter int unsigned DATA_W    = 134,
   parameter int unsigned PHV_W     = 1024,
   parameter int unsigned DEPTH     = 64,
   parameter logic [7:0]  MODULE_ID = 8'd70
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PHV_W-1:0]  in_pgm_phv,
   input  logic              in_pgm_phv_wr,
   output logic              out_pgm_phv_alf,
   input  logic [DATA_W-1:0] in_pgm_data,
   input  logic              in_pgm_data_wr,
   input  logic              in_pgm_valid,
   input  logic              in_pgm_valid_wr,
   output logic              out_pgm_alf,
   output logic [PHV_W-1:0]  out_pgm_phv,
   output logic              out_pgm_phv_wr,
   input  logic              in_pgm_phv_alf,
   output logic [DATA_W-1:0] out_pgm_data,
   output logic              out_pgm_data_wr,
   output logic              out_pgm_valid,
   output logic              out_pgm_valid_wr,
   input  logic              in_pgm_alf,
   output logic              out_pgm_sent_start_flag,
   output logic              out_pgm_sent_finish_flag,
   input  logic [DATA_W-1:0] cin_pgm_data,
   input  logic              cin_pgm_data_wr,
   output logic              cout_pgm_ready,
   output logic [DATA_W-1:0] cout_pgm_data,
   output logic              cout_pgm_data_wr,
   input  logic              cin_pgm_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_WAIT_VLD, S_SEND_PHV, S_SEND_DATA, S_SEND_VLD, S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [PHV_W-1:0]  phv_q, phv_d;
   logic [LW-1:0]     len_q, len_d;
   logic              ovf_q, ovf_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [15:0]       copy_q, copy_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
   logic [15:0]       rep_cnt_q, rep_cnt_d;
   logic [7:0]        gap_q, gap_d;
   logic [15:0]       rep_sh_q, rep_sh_d;
   logic [7:0]        gap_sh_q, gap_sh_d;
   logic [DATA_W-1:0] cout_data_q;
   logic              cout_wr_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;

   logic              cfg_wr;
   logic [15:0]       rep_eff;
   logic              last_copy;
   logic              alf;
   logic [1:0]        in_hdr;

   assign in_hdr = in_pgm_data[DATA_W-1 -: 2];

   // Control chain: forward unchanged, decode register writes on first beats.
   assign cout_pgm_ready   = cin_pgm_ready;
   assign cout_pgm_data    = cout_data_q;
   assign cout_pgm_data_wr = cout_wr_q;

   assign cfg_wr = cin_pgm_data_wr && (cin_pgm_data[DATA_W-1 -: 2] == 2'b01) &&
                   (cin_pgm_data[126:124] == 3'b010) &&
                   (cin_pgm_data[111:104] == MODULE_ID);

   always_comb begin
      rep_cnt_d = rep_cnt_q;
      gap_d     = gap_q;
      if (cfg_wr && cin_pgm_data[103:96] == 8'd61)
         rep_cnt_d = (rep_cnt_q & ~cin_pgm_data[47:32]) | (cin_pgm_data[15:0] & cin_pgm_data[47:32]);
      if (cfg_wr && cin_pgm_data[103:96] == 8'd62)
         gap_d = (gap_q & ~cin_pgm_data[39:32]) | (cin_pgm_data[7:0] & cin_pgm_data[39:32]);
   end

   // A programmed count of 0 still sends one copy.
   assign rep_eff   = (rep_sh_q == 16'd0) ? 16'd1 : rep_sh_q;
   // 17-bit compare so a count of 16'hFFFF cannot wrap the copy counter.
   assign last_copy = (({1'b0, copy_q} + 17'd1) == {1'b0, rep_eff});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      phv_d     = phv_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      rd_ptr_d  = rd_ptr_q;
      copy_d    = copy_q;
      gap_cnt_d = gap_cnt_q;
      rep_sh_d  = rep_sh_q;
      gap_sh_d  = gap_sh_q;
      mem_we    = 1'b0;
      mem_waddr = len_q[AW-1:0];
      case (state_q)
         S_IDLE: begin
            if (in_pgm_phv_wr) begin
               phv_d     = in_pgm_phv;
               rep_sh_d  = rep_cnt_q;
               gap_sh_d  = gap_q;
               ovf_d     = 1'b0;
               len_d     = '0;
               mem_waddr = '0;
               if (in_pgm_data_wr) begin
                  mem_we = 1'b1;
                  len_d  = LW'(1);
               end
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (in_pgm_data_wr) begin
               if (len_q < LW'(DEPTH)) begin
                  mem_we = 1'b1;
                  len_d  = len_q + LW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
               if (in_hdr == 2'b10) state_d = S_WAIT_VLD;
            end
            // An early valid strobe closes the packet even without a last beat.
            if (in_pgm_valid_wr) begin
               state_d  = (!in_pgm_valid || ovf_d) ? S_IDLE : S_SEND_PHV;
               copy_d   = '0;
               rd_ptr_d = '0;
            end
         end
         S_WAIT_VLD: begin
            if (in_pgm_valid_wr) begin
               state_d  = (!in_pgm_valid || ovf_q) ? S_IDLE : S_SEND_PHV;
               copy_d   = '0;
               rd_ptr_d = '0;
            end
         end
         S_SEND_PHV: begin
            if (!in_pgm_phv_alf && !in_pgm_alf) begin
               rd_ptr_d = '0;
               state_d  = (len_q == '0) ? S_SEND_VLD : S_SEND_DATA;
            end
         end
         S_SEND_DATA: begin
            if (!in_pgm_alf) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
               if ((LW'(rd_ptr_q) + LW'(1)) == len_q) begin
                  rd_ptr_d = '0;
                  state_d  = S_SEND_VLD;
               end
            end
         end
         S_SEND_VLD: begin
            copy_d    = copy_q + 16'd1;
            gap_cnt_d = '0;
            if (last_copy)               state_d = S_IDLE;
            else if (gap_sh_q != 8'd0)   state_d = S_GAP;
            else                         state_d = S_SEND_PHV;
         end
         S_GAP: begin
            if (gap_cnt_q == gap_sh_q - 8'd1) state_d = S_SEND_PHV;
            else                               gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      alf                      = 1'b0;
      out_pgm_phv_wr           = 1'b0;
      out_pgm_data_wr          = 1'b0;
      out_pgm_data             = '0;
      out_pgm_valid            = 1'b0;
      out_pgm_valid_wr         = 1'b0;
      out_pgm_sent_start_flag  = 1'b0;
      out_pgm_sent_finish_flag = 1'b0;
      case (state_q)
         S_WAIT_VLD, S_GAP: alf = 1'b1;
         S_SEND_PHV: begin
            alf = 1'b1;
            if (!in_pgm_phv_alf && !in_pgm_alf) begin
               out_pgm_phv_wr          = 1'b1;
               out_pgm_sent_start_flag = (copy_q == 16'd0);
            end
         end
         S_SEND_DATA: begin
            alf = 1'b1;
            if (!in_pgm_alf) begin
               out_pgm_data_wr = 1'b1;
               out_pgm_data    = mem[rd_ptr_q];
            end
         end
         S_SEND_VLD: begin
            alf                      = 1'b1;
            out_pgm_valid            = 1'b1;
            out_pgm_valid_wr         = 1'b1;
            out_pgm_sent_finish_flag = last_copy;
         end
         default: ;
      endcase
   end

   assign out_pgm_alf     = alf;
   assign out_pgm_phv_alf = alf;
   assign out_pgm_phv     = phv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phv_q       <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         rd_ptr_q    <= '0;
         copy_q      <= '0;
         gap_cnt_q   <= '0;
         rep_cnt_q   <= 16'd1;
         gap_q       <= '0;
         rep_sh_q    <= 16'd1;
         gap_sh_q    <= '0;
         cout_data_q <= '0;
         cout_wr_q   <= 1'b0;
      end else begin
         phv_q       <= phv_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         rd_ptr_q    <= rd_ptr_d;
         copy_q      <= copy_d;
         gap_cnt_q   <= gap_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         gap_q       <= gap_d;
         rep_sh_q    <= rep_sh_d;
         gap_sh_q    <= gap_sh_d;
         cout_data_q <= cin_pgm_data;
         cout_wr_q   <= cin_pgm_data_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= in_pgm_data;
   end

endmodule
